// File: rtl/uart_receiver.sv
// ---------------------------------------------------------------------------
// uart_receiver
//
// Recovers 8N1 frames (start bit, 8 data bits LSB first, stop bit) from an
// asynchronous serial line. A fixed CLK_PER_BIT divider sets the bit period.
// The start bit is verified at its midpoint. Each data bit and the stop bit
// are then sampled one full bit period apart, so every sample lands near
// the middle of its bit.
//
// Ports
//   clk         system clock; all logic runs on the rising edge
//   rst_n       asynchronous active-low reset
//   rx          serial line, asynchronous to clk, idles high
//   data_out    last correctly received byte (held until the next good frame)
//   data_valid  one-cycle pulse: data_out was updated this cycle
//   frame_err   one-cycle pulse: the stop bit was sampled low
//   rx_busy     high whenever the receiver is not idle
// ---------------------------------------------------------------------------
module uart_receiver #(
    parameter int CLK_PER_BIT = 217
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int CNT_W = $clog2(CLK_PER_BIT);
    localparam int H     = (CLK_PER_BIT - 1) / 2;

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(H);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } state_t;

    state_t            state, state_n;
    logic              sync1, rx_s;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [2:0]        idx, idx_n;
    logic [7:0]        shreg, shreg_n;
    logic [7:0]        data_out_n;
    logic              data_valid_n, frame_err_n;

    // Two-flop synchroniser. Both flops reset high, so a reset never looks
    // like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= rx;
            rx_s  <= sync1;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            idx        <= '0;
            shreg      <= '0;
            data_out   <= 8'h00;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            idx        <= idx_n;
            shreg      <= shreg_n;
            data_out   <= data_out_n;
            data_valid <= data_valid_n;
            frame_err  <= frame_err_n;
        end
    end

    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        idx_n        = idx;
        shreg_n      = shreg;
        data_out_n   = data_out;
        data_valid_n = 1'b0;
        frame_err_n  = 1'b0;

        unique case (state)
            ST_IDLE: begin
                cnt_n = '0;
                idx_n = '0;
                if (!rx_s) begin
                    state_n = ST_START;
                end
            end

            // Wait half a bit, then confirm the line is still low. A low
            // pulse that has already ended is treated as noise.
            ST_START: begin
                if (cnt < CNT_HALF) begin
                    cnt_n = cnt + CNT_ONE;
                end else begin
                    cnt_n   = '0;
                    state_n = rx_s ? ST_IDLE : ST_DATA;
                end
            end

            ST_DATA: begin
                if (cnt < CNT_LAST) begin
                    cnt_n = cnt + CNT_ONE;
                end else begin
                    cnt_n          = '0;
                    shreg_n[idx]   = rx_s;
                    if (idx == 3'd7) begin
                        idx_n   = '0;
                        state_n = ST_STOP;
                    end else begin
                        idx_n = idx + 3'd1;
                    end
                end
            end

            // Returning to IDLE at mid-stop-bit leaves half a bit of slack,
            // so a start bit that immediately follows is still caught.
            ST_STOP: begin
                if (cnt < CNT_LAST) begin
                    cnt_n = cnt + CNT_ONE;
                end else begin
                    cnt_n = '0;
                    if (rx_s) begin
                        data_out_n   = shreg;
                        data_valid_n = 1'b1;
                        state_n      = ST_IDLE;
                    end else begin
                        frame_err_n = 1'b1;
                        state_n     = ST_BREAK;
                    end
                end
            end

            // A line held low (break) must go high again before a new
            // start bit can be accepted; otherwise it would frame forever.
            ST_BREAK: begin
                cnt_n = '0;
                if (rx_s) begin
                    state_n = ST_IDLE;
                end
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    assign rx_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// ---------------------------------------------------------------------------
// tb_uart_receiver
//
// Drives rx with an ideal 8N1 line model at 16 clocks per bit.
// Every rising edge records the value on the line.
//
// The reference model reconstructs each expected outcome from that record.
// It reads the line at the receiver's sampling instants:
//   - start verify: E0 + H + 1
//   - data bit k:   E0 + H + 1 + (k+1)*CPB
//   - stop bit:     E0 + H + 1 + 9*CPB
// Each of these is the edge at which the synchroniser input sees the bit
// used by the decision two edges later. The result pulse is expected in
// the cycle after E(3 + H + 9*CPB).
// ---------------------------------------------------------------------------
module tb_uart_receiver;

    localparam int CPB  = 16;
    localparam int H    = (CPB - 1) / 2;
    localparam int MAXC = 100000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       rx_busy;

    uart_receiver #(.CLK_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .data_out   (data_out),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .rx_busy    (rx_busy)
    );

    always #5 clk = ~clk;

    int         cyc = 0;
    logic       line     [0:MAXC-1];
    logic       busy_log [0:MAXC-1];
    int         ev_c[$];
    int         ev_k[$];          // 1 = data_valid, 2 = frame_err
    logic [7:0] ev_d[$];
    int         both_cnt = 0;
    int         n_cmp    = 0;
    int         n_fail   = 0;
    logic [7:0] last_good = 8'h00;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (cyc < MAXC) line[cyc] = rx;
    end

    always @(negedge clk) begin
        if (cyc < MAXC) busy_log[cyc] = rx_busy;
        if (data_valid) begin
            ev_c.push_back(cyc); ev_k.push_back(1); ev_d.push_back(data_out);
        end
        if (frame_err) begin
            ev_c.push_back(cyc); ev_k.push_back(2); ev_d.push_back(data_out);
        end
        if (data_valid && frame_err) both_cnt++;
    end

    function automatic void clear_events();
        ev_c.delete(); ev_k.delete(); ev_d.delete();
    endfunction

    function automatic int count_ev(input int kind);
        int n = 0;
        foreach (ev_k[i]) if (ev_k[i] == kind) n++;
        return n;
    endfunction

    function automatic bit find_ev(input int kind, input int c, output logic [7:0] d);
        d = 8'h00;
        foreach (ev_c[i]) begin
            if (ev_c[i] == c && ev_k[i] == kind) begin
                d = ev_d[i];
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    // Reference model: outcome of the frame whose start edge is E0
    function automatic void predict(input int e0, output bit started, output bit good,
                                    output logic [7:0] d, output int pc);
        int s0 = e0 + H + 1;
        started = (line[s0] == 1'b0);
        for (int k = 0; k < 8; k++) d[k] = line[s0 + (k + 1) * CPB];
        good = (line[s0 + 9 * CPB] == 1'b1);
        pc   = e0 + 3 + H + 9 * CPB;
    endfunction

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Called on a negedge; the next rising edge is E0.
    task automatic send_frame(input logic [7:0] b, input int per, input logic stop_bit,
                              output int e0);
        e0 = cyc + 1;
        rx = 1'b0;
        repeat (per) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            rx = b[k];
            repeat (per) @(negedge clk);
        end
        rx = stop_bit;
        repeat (per) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [7:0] d, got;
        bit st, gd, f, busy_ok;
        int e0, pc;
        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data_out: got %h expected 00", data_out); end
        n_cmp++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_data_valid: got %b expected 0", data_valid); end
        n_cmp++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
        n_cmp++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_rx_busy: got %b expected 0", rx_busy); end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        clear_events();
        send_frame(8'hA5, CPB, 1'b1, e0);
        wait_until(e0 + 3 + H + 9 * CPB + 10);
        predict(e0, st, gd, d, pc);
        n_cmp++; if (count_ev(1) !== ((st && gd) ? 1 : 0)) begin n_fail++; $display("FAIL a5_valid_count: got %0d expected 1", count_ev(1)); end
        f = find_ev(1, pc, got);
        n_cmp++; if (!f || got !== d) begin n_fail++; $display("FAIL a5_data: found %b got %h expected %h at cycle %0d", f, got, d, pc); end
        n_cmp++; if (count_ev(2) !== 0) begin n_fail++; $display("FAIL a5_frame_err: got %0d pulses expected 0", count_ev(2)); end
        busy_ok = (busy_log[e0 + 1] === 1'b0) && (busy_log[pc] === 1'b0);
        for (int c = e0 + 2; c < pc; c++) if (busy_log[c] !== 1'b1) busy_ok = 1'b0;
        n_cmp++; if (!busy_ok) begin n_fail++; $display("FAIL a5_rx_busy: got bad profile expected high over E2..E%0d only", pc - e0 - 1); end
        n_cmp++; if (data_out !== d) begin n_fail++; $display("FAIL a5_data_hold: got %h expected %h", data_out, d); end
        last_good = d;
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [3];
        int e0s [3];
        logic [7:0] d, got;
        bit st, gd, f;
        int pc;
        bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'h55;
        clear_events();
        for (int i = 0; i < 3; i++) send_frame(bytes[i], CPB, 1'b1, e0s[i]);
        wait_until(e0s[2] + 3 + H + 9 * CPB + 10);
        n_cmp++; if (count_ev(1) !== 3) begin n_fail++; $display("FAIL b2b_valid_count: got %0d expected 3", count_ev(1)); end
        for (int i = 0; i < 3; i++) begin
            predict(e0s[i], st, gd, d, pc);
            f = find_ev(1, pc, got);
            n_cmp++; if (!f || got !== d) begin n_fail++; $display("FAIL b2b_data%0d: found %b got %h expected %h at cycle %0d", i, f, got, d, pc); end
            last_good = d;
        end
        n_cmp++; if (count_ev(2) !== 0) begin n_fail++; $display("FAIL b2b_frame_err: got %0d pulses expected 0", count_ev(2)); end
    endtask

    task automatic test_frame_error();
        logic [7:0] d, got, prev;
        bit st, gd, f, busy_ok;
        int e0, pc, rise;
        prev = last_good;
        clear_events();
        send_frame(8'h3C, CPB, 1'b0, e0);
        repeat (50 * CPB) @(negedge clk);
        rise = cyc + 1;
        rx   = 1'b1;
        repeat (10) @(negedge clk);
        predict(e0, st, gd, d, pc);
        f = find_ev(2, pc, got);
        n_cmp++; if (f !== (st && !gd) || count_ev(2) !== ((st && !gd) ? 1 : 0)) begin n_fail++; $display("FAIL ferr_pulse: found %b count %0d expected one at cycle %0d", f, count_ev(2), pc); end
        n_cmp++; if (count_ev(1) !== 0) begin n_fail++; $display("FAIL ferr_no_valid: got %0d pulses expected 0", count_ev(1)); end
        n_cmp++; if (data_out !== prev) begin n_fail++; $display("FAIL ferr_data_hold: got %h expected %h", data_out, prev); end
        busy_ok = (busy_log[rise + 2] === 1'b0);
        for (int c = e0 + 2; c <= rise + 1; c++) if (busy_log[c] !== 1'b1) busy_ok = 1'b0;
        n_cmp++; if (!busy_ok) begin n_fail++; $display("FAIL ferr_rx_busy: got bad profile expected high until cycle %0d", rise + 1); end
        clear_events();
        send_frame(8'h81, CPB, 1'b1, e0);
        wait_until(e0 + 3 + H + 9 * CPB + 10);
        predict(e0, st, gd, d, pc);
        f = find_ev(1, pc, got);
        n_cmp++; if (!f || got !== d || count_ev(1) !== 1) begin n_fail++; $display("FAIL ferr_next_81: found %b got %h expected %h", f, got, d); end
        last_good = d;
    endtask

    task automatic test_glitch();
        logic [7:0] d, got;
        bit st, gd, f;
        int e0, pc;
        clear_events();
        e0 = cyc + 1;
        rx = 1'b0;
        repeat (5) @(negedge clk);
        rx = 1'b1;
        wait_until(e0 + 40);
        predict(e0, st, gd, d, pc);
        n_cmp++; if (count_ev(1) + count_ev(2) !== (st ? 1 : 0)) begin n_fail++; $display("FAIL glitch_no_pulse: got %0d pulses expected 0", count_ev(1) + count_ev(2)); end
        n_cmp++; if (busy_log[e0 + 2] !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_rise: got %b expected 1", busy_log[e0 + 2]); end
        n_cmp++; if (busy_log[e0 + 4 + H] !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_fall: got %b expected 0", busy_log[e0 + 4 + H]); end
        clear_events();
        send_frame(8'h7E, CPB, 1'b1, e0);
        wait_until(e0 + 3 + H + 9 * CPB + 10);
        predict(e0, st, gd, d, pc);
        f = find_ev(1, pc, got);
        n_cmp++; if (!f || got !== d || count_ev(1) !== 1) begin n_fail++; $display("FAIL glitch_next_7e: found %b got %h expected %h", f, got, d); end
        last_good = d;
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] b, d, got;
        bit st, gd, f;
        int e0, pc;
        b  = 8'hC3;
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            rx = b[k];
            repeat (CPB) @(negedge clk);
        end
        rx = b[4];
        repeat (CPB / 2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL rstmid_data_out: got %h expected 00", data_out); end
        n_cmp++; if (rx_busy !== 1'b0 || data_valid !== 1'b0 || frame_err !== 1'b0) begin n_fail++; $display("FAIL rstmid_flags: got busy %b valid %b err %b expected 000", rx_busy, data_valid, frame_err); end
        rx = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        last_good = 8'h00;
        clear_events();
        repeat (3) @(negedge clk);
        send_frame(8'h12, CPB, 1'b1, e0);
        wait_until(e0 + 3 + H + 9 * CPB + 10);
        predict(e0, st, gd, d, pc);
        f = find_ev(1, pc, got);
        n_cmp++; if (!f || got !== d) begin n_fail++; $display("FAIL rstmid_12: found %b got %h expected %h", f, got, d); end
        n_cmp++; if (count_ev(1) !== 1 || count_ev(2) !== 0) begin n_fail++; $display("FAIL rstmid_spurious: got %0d valid %0d err expected 1 and 0", count_ev(1), count_ev(2)); end
        last_good = d;
    endtask

    task automatic test_clock_tolerance();
        logic [7:0] d, got;
        bit st, gd, f;
        int e0, pc, per;
        for (int i = 0; i < 2; i++) begin
            per = (i == 0) ? 17 : 15;
            clear_events();
            repeat (5) @(negedge clk);
            send_frame(8'h96, per, 1'b1, e0);
            wait_until(e0 + 3 + H + 9 * CPB + 20);
            predict(e0, st, gd, d, pc);
            f = find_ev(1, pc, got);
            n_cmp++; if (!f || got !== d || count_ev(1) !== 1) begin n_fail++; $display("FAIL tol_%0d: found %b got %h expected %h", per, f, got, d); end
            if (f) last_good = d;
        end
    endtask

    task automatic test_random();
        localparam int N = 12;
        logic [7:0] bs [N];
        int e0s [N];
        logic [7:0] d, got;
        bit st, gd, f;
        int pc;
        clear_events();
        for (int i = 0; i < N; i++) begin
            bs[i] = 8'($urandom_range(0, 255));
            repeat ($urandom_range(0, 20)) @(negedge clk);
            send_frame(bs[i], CPB, 1'b1, e0s[i]);
        end
        wait_until(e0s[N - 1] + 3 + H + 9 * CPB + 10);
        n_cmp++; if (count_ev(1) !== N) begin n_fail++; $display("FAIL rand_count: got %0d expected %0d", count_ev(1), N); end
        for (int i = 0; i < N; i++) begin
            predict(e0s[i], st, gd, d, pc);
            f = find_ev(1, pc, got);
            n_cmp++; if (!f || got !== d) begin n_fail++; $display("FAIL rand_%0d: found %b got %h expected %h", i, f, got, d); end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        rx    = 1'b1;
        test_reset();
        test_back_to_back();
        test_frame_error();
        test_glitch();
        test_reset_mid_frame();
        test_clock_tolerance();
        test_random();
        n_cmp++; if (both_cnt !== 0) begin n_fail++; $display("FAIL exclusive_pulses: got %0d overlapping cycles expected 0", both_cnt); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
